// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the vga_adapter pixel port, fills one granted rectangle per request at one pixel per clock.
// Optional clipping to SCREEN_W x SCREEN_H is built when VGA_DRAW_CLIP_EN is defined.
module vga_draw_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_x,
  input  logic [NUM_REQ*7-1:0] req_y,
  input  logic [NUM_REQ*8-1:0] req_wm1,
  input  logic [NUM_REQ*7-1:0] req_hm1,
  input  logic [NUM_REQ*3-1:0] req_colour,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot
);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t state_q;
  logic [2:0] rr_last_q, grant_id_q, win;
  logic found, on_screen, last_px;
  logic [7:0] x0_q, wm1_q, cx_q, vga_x_q;
  logic [6:0] y0_q, hm1_q, cy_q, vga_y_q;
  logic [2:0] col_q, vga_colour_q;
  logic [NUM_REQ-1:0] ack_q, done_q;
  logic busy_q, vga_plot_q;
  if (NUM_REQ < 2 || NUM_REQ > 8 || SCREEN_W > 256 || SCREEN_H > 128) begin : g_bad_cfg
    $error("vga_draw_arbiter: unsupported configuration");
  end
  // Scan from farthest to nearest so the closest requester after rr_last wins.
  always_comb begin
    win = rr_last_q;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (|(req & (NUM_REQ'(1) << ((int'(rr_last_q) + k) % NUM_REQ)))) begin
        found = 1'b1;
        win = 3'((int'(rr_last_q) + k) % NUM_REQ);
      end
    end
  end
  assign last_px = (cx_q == wm1_q) && (cy_q == hm1_q);
`ifdef VGA_DRAW_CLIP_EN
  logic [8:0] px;
  logic [7:0] py;
  assign px = {1'b0, x0_q} + {1'b0, cx_q};
  assign py = {1'b0, y0_q} + {1'b0, cy_q};
  assign on_screen = (int'(px) < SCREEN_W) && (int'(py) < SCREEN_H);
`else
  assign on_screen = 1'b1;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_last_q <= 3'(NUM_REQ - 1);
      grant_id_q <= '0;
      x0_q <= '0;
      y0_q <= '0;
      wm1_q <= '0;
      hm1_q <= '0;
      col_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      ack_q <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_colour_q <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      ack_q <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          vga_plot_q <= 1'b0;
          if (found) begin
            x0_q <= 8'(req_x >> (8 * win));
            y0_q <= 7'(req_y >> (7 * win));
            wm1_q <= 8'(req_wm1 >> (8 * win));
            hm1_q <= 7'(req_hm1 >> (7 * win));
            col_q <= 3'(req_colour >> (3 * win));
            cx_q <= '0;
            cy_q <= '0;
            grant_id_q <= win;
            rr_last_q <= win;
            busy_q <= 1'b1;
            ack_q <= NUM_REQ'(1) << win;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          vga_x_q <= x0_q + cx_q;
          vga_y_q <= y0_q + cy_q;
          vga_colour_q <= col_q;
          vga_plot_q <= on_screen;
          cx_q <= (cx_q == wm1_q) ? 8'd0 : cx_q + 8'd1;
          cy_q <= (cx_q == wm1_q) ? cy_q + 7'd1 : cy_q;
          if (last_px) state_q <= DONE;
        end
        default: begin
          vga_plot_q <= 1'b0;
          done_q <= NUM_REQ'(1) << grant_id_q;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign ack = ack_q;
  assign done = done_q;
  assign busy = busy_q;
  assign grant_id = grant_id_q;
  assign vga_x = vga_x_q;
  assign vga_y = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot = vga_plot_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed stimulus with a queue of expected ack/pixel/done events checked by a forked monitor.
module tb_vga_draw_arbiter;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*8-1:0] req_x = '0;
  logic [N*7-1:0] req_y = '0;
  logic [N*8-1:0] req_wm1 = '0;
  logic [N*7-1:0] req_hm1 = '0;
  logic [N*3-1:0] req_colour = '0;
  logic [N-1:0] ack, done;
  logic busy, vga_plot;
  logic [2:0] grant_id, vga_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  always #5 clock = ~clock;
  vga_draw_arbiter #(.NUM_REQ(N), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_wm1(req_wm1), .req_hm1(req_hm1), .req_colour(req_colour),
    .ack(ack), .done(done), .busy(busy), .grant_id(grant_id),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  // kind: 0 ack, 1 pixel, 2 done; gap = quiet cycles since previous event, -1 = any
  typedef struct {int kind; int ch; int x; int y; int col; int gap;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0, quiet = 0, busy_cnt = 0;
  task automatic push(input int kind, input int ch, input int x, input int y, input int col, input int gap);
    ev_t e;
    e.kind = kind; e.ch = ch; e.x = x; e.y = y; e.col = col; e.gap = gap;
    q.push_back(e);
  endtask
  task automatic exp_rect(input int ch, input int x, input int y, input int wm1, input int hm1,
                          input int col, input int gap, input int upto);
    int g, n;
    g = 0;
    n = 0;
    push(0, ch, 0, 0, 0, gap);
    for (int r = 0; r <= hm1; r++)
      for (int c = 0; c <= wm1; c++) begin
        if (upto < 0 || n < upto) begin
`ifdef VGA_DRAW_CLIP_EN
          if (x + c >= 160 || y + r >= 120) g++;
          else begin
            push(1, ch, (x + c) % 256, (y + r) % 128, col, g);
            g = 0;
          end
`else
          push(1, ch, (x + c) % 256, (y + r) % 128, col, 0);
`endif
        end
        n++;
      end
    if (upto < 0) push(2, ch, 0, 0, 0, g);
  endtask
  task automatic set_ch(input int ch, input int x, input int y, input int wm1, input int hm1, input int col);
    req_x[ch*8 +: 8] = 8'(x);
    req_y[ch*7 +: 7] = 7'(y);
    req_wm1[ch*8 +: 8] = 8'(wm1);
    req_hm1[ch*7 +: 7] = 7'(hm1);
    req_colour[ch*3 +: 3] = 3'(col);
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic mon();
    ev_t e;
    bit ok;
    if (reset) begin
      quiet = 0;
      return;
    end
    busy_cnt += int'(busy);
    if (ack == 0 && done == 0 && !vga_plot) begin
      quiet++;
      return;
    end
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual ack=%b done=%b plot=%b x=%0d y=%0d required no event",
               ack, done, vga_plot, vga_x, vga_y);
    end else begin
      e = q.pop_front();
      ok = (e.gap < 0) || (e.gap == quiet);
      if (e.kind == 0)
        ok = ok && ack == N'(1 << e.ch) && done == 0 && !vga_plot && busy && grant_id == 3'(e.ch);
      else if (e.kind == 1)
        ok = ok && vga_plot && ack == 0 && done == 0 && busy && vga_x == 8'(e.x) && vga_y == 7'(e.y)
             && vga_colour == 3'(e.col);
      else
        ok = ok && done == N'(1 << e.ch) && ack == 0 && !vga_plot && !busy;
      if (!ok) begin
        errors++;
        $display("FAIL event kind=%0d ch=%0d actual ack=%b done=%b plot=%b busy=%b gid=%0d x=%0d y=%0d col=%0d gap=%0d required x=%0d y=%0d col=%0d gap=%0d",
                 e.kind, e.ch, ack, done, vga_plot, busy, grant_id, vga_x, vga_y, vga_colour, quiet,
                 e.x, e.y, e.col, e.gap);
      end
    end
    quiet = 0;
  endtask
  // Requesters drop req on their ack unless held; all drop once nacks grants have been seen.
  task automatic drive(input logic [N-1:0] hold, input int nacks, input int budget, input string name);
    int a, t;
    a = 0;
    t = 0;
    while (!(q.size() == 0 && !busy && req == 0) && t < budget) begin
      @(negedge clock);
      t++;
      if (ack != 0) a++;
      req = req & ~(ack & ~hold);
      if (nacks > 0 && a >= nacks) req = '0;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL %s timeout actual=%0d cycles required below %0d, %0d events pending", name, t, budget, q.size());
      q.delete();
      req = '0;
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask
  initial begin
    int cnt, t;
    fork
      forever begin
        @(negedge clock);
        mon();
      end
    join_none
    repeat (3) @(negedge clock);
    check("rst_ack", int'(ack), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_colour", int'(vga_colour), 0);
    check("rst_plot", int'(vga_plot), 0);
    reset = 1'b0;
    // single 16x2 rectangle on channel 1
    set_ch(1, 76, 110, 15, 1, 7);
    exp_rect(1, 76, 110, 15, 1, 7, -1, -1);
    @(negedge clock);
    busy_cnt = 0;
    req[1] = 1'b1;
    @(negedge clock);
    check("t1_ack_next_cycle", int'(ack), 2);
    req = '0;
    drive('0, 0, 100, "t1");
    repeat (2) @(negedge clock);
    check("t1_busy_cycles", busy_cnt, 33);
    // simultaneous 1x1 requests on 0, 2, 3 from reset, twice
    do_reset();
    set_ch(0, 1, 2, 0, 0, 1);
    set_ch(2, 3, 4, 0, 0, 2);
    set_ch(3, 5, 6, 0, 0, 3);
    for (int p = 0; p < 2; p++) begin
      exp_rect(0, 1, 2, 0, 0, 1, -1, -1);
      exp_rect(2, 3, 4, 0, 0, 2, 0, -1);
      exp_rect(3, 5, 6, 0, 0, 3, 0, -1);
      @(negedge clock);
      req = 4'b1101;
      drive('0, 0, 100, "t2_rr");
    end
    // channels 0 and 2 held continuously alternate
    exp_rect(0, 1, 2, 0, 0, 1, -1, -1);
    exp_rect(2, 3, 4, 0, 0, 2, 0, -1);
    exp_rect(0, 1, 2, 0, 0, 1, 0, -1);
    exp_rect(2, 3, 4, 0, 0, 2, 0, -1);
    @(negedge clock);
    req = 4'b0101;
    drive(4'b0101, 4, 100, "t2_fair");
    // full-screen clear
    set_ch(1, 0, 0, 159, 119, 0);
    exp_rect(1, 0, 0, 159, 119, 0, -1, -1);
    @(negedge clock);
    req[1] = 1'b1;
    drive('0, 0, 19400, "t3_clear");
    // reset while the 5th pixel of an 8x2 draw is on the port
    set_ch(0, 10, 20, 7, 1, 5);
    exp_rect(0, 10, 20, 7, 1, 5, -1, 5);
    @(negedge clock);
    req[0] = 1'b1;
    cnt = 0;
    t = 0;
    while (cnt < 5 && t < 50) begin
      @(negedge clock);
      t++;
      if (ack[0]) req[0] = 1'b0;
      if (vga_plot) cnt++;
    end
    check("t4_pixels_before_reset", cnt, 5);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("t4_plot_after_reset", int'(vga_plot), 0);
    check("t4_busy_after_reset", int'(busy), 0);
    check("t4_done_after_reset", int'(done), 0);
    @(negedge clock);
    reset = 1'b0;
    check("t4_pending_events", q.size(), 0);
    repeat (4) @(negedge clock);
    set_ch(2, 30, 40, 0, 1, 6);
    exp_rect(2, 30, 40, 0, 1, 6, -1, -1);
    req[2] = 1'b1;
    drive('0, 0, 100, "t4_fresh");
    // req[3] pulse while busy is ignored; a stable req[3] follows done[0]
    set_ch(0, 50, 60, 3, 0, 4);
    set_ch(3, 70, 80, 1, 0, 2);
    exp_rect(0, 50, 60, 3, 0, 4, -1, -1);
    exp_rect(3, 70, 80, 1, 0, 2, 0, -1);
    @(negedge clock);
    req[0] = 1'b1;
    @(negedge clock);
    req[0] = 1'b0;
    @(negedge clock);
    req[3] = 1'b1;
    @(negedge clock);
    req[3] = 1'b0;
    @(negedge clock);
    req[3] = 1'b1;
    drive('0, 0, 100, "t5");
    // rectangle crossing the right/bottom screen edges
    set_ch(1, 156, 118, 7, 3, 3);
    exp_rect(1, 156, 118, 7, 3, 3, -1, -1);
    @(negedge clock);
    req[1] = 1'b1;
    drive('0, 0, 100, "t6_edge");
    // widest row wraps x past 255
    set_ch(1, 200, 5, 255, 0, 6);
    exp_rect(1, 200, 5, 255, 0, 6, -1, -1);
    @(negedge clock);
    req[1] = 1'b1;
    drive('0, 0, 400, "t7_wrap");
    repeat (3) @(negedge clock);
    check("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
